min_receive_fsm: RTL

MIN_RECEIVE_FSM -- requirements
Module: min_receive_fsm

---
 rtl/min_receive_fsm.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/min_receive_fsm.sv
// MIN frame receiver: hunts for the 0xAA x3 SOF, unstuffs, collects ID/LEN/payload/CRC-32
// in shadow registers and publishes them only when a frame ends with good CRC and EOF.
module min_receive_fsm #(
   parameter int unsigned N_DATA_BYTE = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_en,
   input  logic                     i_valid,
   input  logic [7:0]               i_data,
   output logic                     o_valid,
   output logic [7:0]               o_id,
   output logic [7:0]               o_len,
   output logic [8*N_DATA_BYTE-1:0] o_data,
   output logic                     o_err,
   output logic                     o_busy
);

   localparam int unsigned DW = 8 * N_DATA_BYTE;

   typedef enum logic [2:0] {StHunt, StId, StLen, StPayload, StCrc, StEof} state_e;

   state_e        state_q;
   logic [1:0]    aa_cnt_q;
   logic [7:0]    byte_cnt_q;
   logic [31:0]   crc_q;
   logic [31:0]   crc_rx_q;
   logic [7:0]    id_sh_q;
   logic [7:0]    len_sh_q;
   logic [DW-1:0] data_sh_q;
   logic          valid_q;
   logic          err_q;
   logic [7:0]    id_q;
   logic [7:0]    len_q;
   logic [DW-1:0] data_q;

   logic          acc;
   logic          is_aa;
   logic          is_55;
   logic          start_frame;
   logic          len_bad;
   logic [31:0]   crc_d;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return c;
   endfunction

   assign acc         = i_valid & i_en;
   assign is_aa       = (i_data == 8'hAA);
   assign is_55       = (i_data == 8'h55);
   // A third consecutive 0xAA is always a SOF, whether hunting or mid-frame.
   assign start_frame = acc & is_aa & (aa_cnt_q == 2'd2);
   assign len_bad     = (i_data > 8'(N_DATA_BYTE));
   assign crc_d       = crc32_byte(crc_q, i_data);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StHunt;
         aa_cnt_q   <= 2'd0;
         byte_cnt_q <= 8'd0;
         crc_q      <= 32'hFFFF_FFFF;
         crc_rx_q   <= 32'h0;
         id_sh_q    <= 8'h0;
         len_sh_q   <= 8'h0;
         data_sh_q  <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         id_q       <= 8'h0;
         len_q      <= 8'h0;
         data_q     <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (start_frame) begin
            state_q    <= StId;
            aa_cnt_q   <= 2'd0;
            byte_cnt_q <= 8'd0;
            crc_q      <= 32'hFFFF_FFFF;
            crc_rx_q   <= 32'h0;
            id_sh_q    <= 8'h0;
            len_sh_q   <= 8'h0;
            data_sh_q  <= '0;
         end else if (acc && state_q == StHunt) begin
            aa_cnt_q <= is_aa ? aa_cnt_q + 2'd1 : 2'd0;
         end else if (acc && aa_cnt_q == 2'd2) begin
            // Stuff byte after two in-frame 0xAA; anything but 0x55 here is a framing error.
            aa_cnt_q <= 2'd0;
            if (!is_55) begin
               state_q <= StHunt;
               err_q   <= 1'b1;
            end
         end else if (acc) begin
            aa_cnt_q <= is_aa ? aa_cnt_q + 2'd1 : 2'd0;
            unique case (state_q)
               StId: begin
                  id_sh_q <= i_data;
                  crc_q   <= crc_d;
                  state_q <= StLen;
               end
               StLen: begin
                  if (len_bad) begin
                     err_q    <= 1'b1;
                     aa_cnt_q <= 2'd0;
                     state_q  <= StHunt;
                  end else begin
                     len_sh_q   <= i_data;
                     crc_q      <= crc_d;
                     byte_cnt_q <= 8'd0;
                     state_q    <= (i_data == 8'd0) ? StCrc : StPayload;
                  end
               end
               StPayload: begin
                  for (int k = 0; k < int'(N_DATA_BYTE); k++) begin
                     if (byte_cnt_q == 8'(k)) data_sh_q[DW-1-8*k -: 8] <= i_data;
                  end
                  crc_q <= crc_d;
                  if (byte_cnt_q + 8'd1 == len_sh_q) begin
                     byte_cnt_q <= 8'd0;
                     state_q    <= StCrc;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 8'd1;
                  end
               end
               StCrc: begin
                  crc_rx_q <= {crc_rx_q[23:0], i_data};
                  if (byte_cnt_q == 8'd3) begin
                     byte_cnt_q <= 8'd0;
                     state_q    <= StEof;
                  end else begin
                     byte_cnt_q <= byte_cnt_q + 8'd1;
                  end
               end
               StEof: begin
                  aa_cnt_q <= 2'd0;
                  state_q  <= StHunt;
                  if (is_55 && ((crc_q ^ 32'hFFFF_FFFF) == crc_rx_q)) begin
                     valid_q <= 1'b1;
                     id_q    <= id_sh_q;
                     len_q   <= len_sh_q;
                     data_q  <= data_sh_q;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_valid = valid_q;
   assign o_err   = err_q;
   assign o_id    = id_q;
   assign o_len   = len_q;
   assign o_data  = data_q;
   assign o_busy  = (state_q != StHunt);

endmodule
